des_round_controller: RTL and testbench
=======================================

Name: des_round_controller

Overview:
- Sequencer for the iterative DES core. Accepts a start request and runs one Feistel round per clock on the shared round datapath (expansion box, S-boxes, P-box).
- Owns the C/D key-schedule register. Presents the rotated 56-bit C/D value for each round; PC-2 and the datapath sit outside this block.
- Emits load, round-enable and final-capture strobes. Holds a done flag until acknowledged.

Parameters:
- ROUNDS, 16, number of rounds run per operation; legal 1..16; reduced values exist for round-reduction security experiments.

Ports:
- wClk  in  1  clock; all logic on the rising edge.
- wReset  in  1  synchronous, active-high reset.
- wStart  in  1  start request; sampled only in IDLE.
- wDecrypt  in  1  1 = decrypt, 0 = encrypt; latched on start acceptance.
- wKeyCD  in  56  post-PC-1 key; [56:29] = C, [28:1] = D; latched on start acceptance.
- wAck  in  1  result consumed; sampled only in DONE.
- rBusy  out  1  high in LOAD, ROUND and FINAL.
- rLoad  out  1  one-cycle pulse; datapath loads IP(block) into L/R.
- rRoundEn  out  1  high in ROUND; datapath performs L<=R, R<=L^f(R,K).
- rRound  out  4  current round index, 0..ROUNDS-1.
- rSubKeyCD  out  56  C/D value for the current round; feeds PC-2.
- rFinal  out  1  one-cycle pulse; datapath captures FP(R,L).
- rDone  out  1  result valid; held until wAck.

Behaviour:
- Reset (synchronous, active high, wins over everything):
  - State goes to IDLE.
  - All outputs are 0, including rSubKeyCD and rRound.
  - Latched mode and key are 0.
  - Reset in any state aborts the operation with no further strobes.
- Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- K_r is C and D each rotated left by (S[1] + ... + S[r]); K_0 = wKeyCD.
- States and transitions:
  - IDLE: if wStart=1, go to LOAD and latch wDecrypt.
    - Encrypt: rSubKeyCD <= K_1.
    - Decrypt: rSubKeyCD <= K_ROUNDS, computed from a constant total rotation (ROUNDS=16 gives K_0).
  - LOAD (1 cycle): rLoad=1. Go to ROUND with rRound=0.
  - ROUND (ROUNDS cycles): rRoundEn=1. rSubKeyCD is the key for round rRound.
    - At the end of each round cycle where rRound < ROUNDS-1: increment rRound and update rSubKeyCD.
    - Encrypt: rotate left by S[rRound+2].
    - Decrypt: rotate right by S[ROUNDS-rRound].
    - After round ROUNDS-1, go to FINAL.
  - FINAL (1 cycle): rFinal=1, rBusy=1. Go to DONE.
  - DONE: rDone=1, rBusy=0. If wAck=1, go to IDLE next cycle (rDone drops).
- Timing: start sampled at cycle T gives rLoad at T+1, rounds at T+2..T+ROUNDS+1, rFinal at T+ROUNDS+2, rDone at T+ROUNDS+3. Default latency is 19 cycles.
- Ignored inputs:
  - wStart outside IDLE.
  - wAck outside DONE.
  - wStart and wAck high together in DONE: only the ack acts; a new start needs IDLE.
- Held values:
  - wKeyCD and wDecrypt changing mid-operation have no effect.
  - rSubKeyCD and rRound hold their last values in FINAL, DONE and IDLE.
- Invariant: rLoad, rRoundEn and rFinal are mutually exclusive.
- Rotation is within each 28-bit half only; no bits cross between C and D.

Decomposition:
- Package des_pkg holds:
  - the S[] shift table;
  - the state encoding (IDLE, LOAD, ROUND, FINAL, DONE);
  - a constant function for the cumulative rotation sum up to r;
  - widths (half-key 28, key 56, round index 4).
- One sub-module: des_key_rotator, purely combinational. Inputs are 56-bit C/D, 2-bit amount (1 or 2) and a direction bit; it rotates both halves independently.

Test Plan:
- Encrypt, wKeyCD C=28'h0000001 D=28'h8000000:
  - rLoad at T+1.
  - rSubKeyCD round 0 = C 0000002 / D 0000001; round 1 = 0000004/0000002; round 2 = 0000010/0000008.
  - Round 15 = 0000001/8000000.
  - rFinal at T+18, rDone at T+19.
- Decrypt, same key:
  - Round 0 = 0000001/8000000; round 1 = 8000000/4000000; round 2 = 2000000/1000000.
  - Round 15 equals the encrypt round-0 value.
- Hold-until-ack:
  - wAck withheld for 10 cycles: rDone stays 1, no strobes.
  - wAck pulse: rDone=0 next cycle. wStart in the same cycle is ignored, then accepted one cycle later.
- Reset at T+9 mid-ROUND: next cycle all outputs 0, state IDLE. A fresh start yields the full 19-cycle sequence.
- Ignored inputs during ROUND:
  - wStart toggling has no effect on rRound progression.
  - wKeyCD and wDecrypt changes do not alter the subkey sequence.
  - wAck outside DONE is ignored.
- ROUNDS=4 encrypt: 4 round cycles with subkeys K_1..K_4, rDone at T+7. Decrypt starts at K_4 (rotation 6).

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants, state encoding and rotation helpers for the DES round sequencer.
// Holds the per-round shift table S[1..16] (stored 0-based) and cumulative-rotation math.
package des_pkg;

  localparam int HALF_W = 28;
  localparam int KEY_W  = 56;
  localparam int RND_W  = 4;

  // SHIFTS[r-1] is S[r]
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_t;

  // S[1] + ... + S[r]
  function automatic int cum_shift(input int r);
    int s;
    s = 0;
    for (int i = 0; i < r; i++) begin
      s += int'(SHIFTS[i]);
    end
    return s;
  endfunction

  // n must be 0..27
  function automatic logic [HALF_W-1:0] rotl_half(
    input logic [HALF_W-1:0] x,
    input int                n
  );
    return (x << n) | (x >> (HALF_W - n));
  endfunction

endpackage

// File: rtl/des_key_rotator.sv
// Combinational C/D rotator: both 28-bit halves rotate by 1 or 2, left or right.
// Ports: cd (C in [55:28], D in [27:0]), amt (1 or 2), dir (1 = right), rotated.
module des_key_rotator
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] cd,
  input  logic [1:0]       amt,
  input  logic             dir,
  output logic [KEY_W-1:0] rotated
);

  function automatic logic [HALF_W-1:0] rot(
    input logic [HALF_W-1:0] x,
    input logic              two,
    input logic              right
  );
    logic [HALF_W-1:0] y;
    unique case ({right, two})
      2'b00:   y = {x[26:0], x[27]};
      2'b01:   y = {x[25:0], x[27:26]};
      2'b10:   y = {x[0], x[27:1]};
      default: y = {x[1:0], x[27:2]};
    endcase
    return y;
  endfunction

  logic two;

  assign two = (amt == 2'd2);

  assign rotated = {
    rot(cd[55:28], two, dir),
    rot(cd[27:0], two, dir)
  };

endmodule

// File: rtl/des_round_controller.sv
// Iterative DES round sequencer: LOAD, ROUNDS x ROUND, FINAL, then DONE until acked.
// Ports: wStart/wDecrypt/wKeyCD/wAck in; rBusy/rLoad/rRoundEn/rRound/rSubKeyCD/rFinal/rDone out.
module des_round_controller
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic             wClk,
  input  logic             wReset,
  input  logic             wStart,
  input  logic             wDecrypt,
  input  logic [KEY_W-1:0] wKeyCD,
  input  logic             wAck,
  output logic             rBusy,
  output logic             rLoad,
  output logic             rRoundEn,
  output logic [RND_W-1:0] rRound,
  output logic [KEY_W-1:0] rSubKeyCD,
  output logic             rFinal,
  output logic             rDone
);

  // Decrypt begins at K_ROUNDS; a full 16-round schedule wraps to K_0
  localparam int DEC_ROT = cum_shift(ROUNDS) % HALF_W;

  state_t state, state_nx;

  logic             dec_q;
  logic             last;
  logic [RND_W-1:0] sidx;
  logic [KEY_W-1:0] rot_in;
  logic [KEY_W-1:0] rot_out;
  logic [KEY_W-1:0] dec_first;
  logic [1:0]       rot_amt;
  logic             rot_dir;

  assign last = (rRound == RND_W'(ROUNDS - 1));

  assign dec_first = {
    rotl_half(wKeyCD[55:28], DEC_ROT),
    rotl_half(wKeyCD[27:0], DEC_ROT)
  };

  // Encrypt steps forward with S[rRound+2];
  // decrypt walks back with S[ROUNDS-rRound]
  always_comb begin
    sidx    = dec_q ? RND_W'(ROUNDS - 1) - rRound
                    : rRound + 4'd1;
    rot_in  = rSubKeyCD;
    rot_amt = SHIFTS[sidx];
    rot_dir = dec_q;
    if (state == IDLE) begin
      rot_in  = wKeyCD;
      rot_amt = SHIFTS[0];
      rot_dir = 1'b0;
    end
  end

  des_key_rotator u_rot (
    .cd      (rot_in),
    .amt     (rot_amt),
    .dir     (rot_dir),
    .rotated (rot_out)
  );

  always_ff @(posedge wClk) begin
    if (wReset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rBusy    = 1'b0;
    rLoad    = 1'b0;
    rRoundEn = 1'b0;
    rFinal   = 1'b0;
    rDone    = 1'b0;
    unique case (state)
      IDLE: begin
        if (wStart) state_nx = LOAD;
      end
      LOAD: begin
        rBusy    = 1'b1;
        rLoad    = 1'b1;
        state_nx = ROUND;
      end
      ROUND: begin
        rBusy    = 1'b1;
        rRoundEn = 1'b1;
        if (last) state_nx = FINAL;
      end
      FINAL: begin
        rBusy    = 1'b1;
        rFinal   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        rDone = 1'b1;
        if (wAck) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wClk) begin
    if (wReset) begin
      dec_q     <= 1'b0;
      rRound    <= '0;
      rSubKeyCD <= '0;
    end else if (state == IDLE && wStart) begin
      dec_q     <= wDecrypt;
      rSubKeyCD <= wDecrypt ? dec_first : rot_out;
    end else if (state == LOAD) begin
      rRound <= '0;
    end else if (state == ROUND && !last) begin
      rRound    <= rRound + 4'd1;
      rSubKeyCD <= rot_out;
    end
  end

endmodule

// File: tb/tb_des_round_controller.sv
// Directed bench for des_round_controller with ROUNDS=16 and ROUNDS=4 instances.
// Expected subkeys are queued at start and popped on each round cycle.
module tb_des_round_controller;

  logic        wClk = 1'b0;
  logic        wReset, wStart, wDecrypt, wAck;
  logic [55:0] wKeyCD;

  logic        busy_a, load_a, ren_a, fin_a, done_a;
  logic [3:0]  rnd_a;
  logic [55:0] sk_a;
  logic        busy_b, load_b, ren_b, fin_b, done_b;
  logic [3:0]  rnd_b;
  logic [55:0] sk_b;

  logic        busy, load, ren, fin, done;
  logic [3:0]  rnd;
  logic [55:0] sk;

  bit          sel4;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [55:0] exp_q[$];
  logic [55:0] obs_k[16];

  localparam logic [55:0] K = {28'h0000001, 28'h8000000};

  int sh[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 wClk = ~wClk;

  des_round_controller #(.ROUNDS(16)) dut_a (
    .wClk(wClk), .wReset(wReset), .wStart(wStart),
    .wDecrypt(wDecrypt), .wKeyCD(wKeyCD), .wAck(wAck),
    .rBusy(busy_a), .rLoad(load_a), .rRoundEn(ren_a),
    .rRound(rnd_a), .rSubKeyCD(sk_a), .rFinal(fin_a),
    .rDone(done_a)
  );

  des_round_controller #(.ROUNDS(4)) dut_b (
    .wClk(wClk), .wReset(wReset), .wStart(wStart),
    .wDecrypt(wDecrypt), .wKeyCD(wKeyCD), .wAck(wAck),
    .rBusy(busy_b), .rLoad(load_b), .rRoundEn(ren_b),
    .rRound(rnd_b), .rSubKeyCD(sk_b), .rFinal(fin_b),
    .rDone(done_b)
  );

  always_comb begin
    busy = sel4 ? busy_b : busy_a;
    load = sel4 ? load_b : load_a;
    ren  = sel4 ? ren_b  : ren_a;
    fin  = sel4 ? fin_b  : fin_a;
    done = sel4 ? done_b : done_a;
    rnd  = sel4 ? rnd_b  : rnd_a;
    sk   = sel4 ? sk_b   : sk_a;
  end

  function automatic logic [55:0] mrot(input logic [55:0] k, input int n);
    logic [27:0] c, d;
    c = k[55:28];
    d = k[27:0];
    for (int i = 0; i < n % 28; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

  function automatic int cum(input int r);
    int s;
    s = 0;
    for (int i = 0; i < r; i++) s += sh[i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge in DONE.
  task automatic run_op(input bit dec, input logic [55:0] key,
                        input int nr, input bit disturb);
    logic [55:0] expk;
    expk = '0;
    for (int i = 0; i < nr; i++)
      exp_q.push_back(dec ? mrot(key, cum(nr - i)) : mrot(key, cum(i + 1)));
    wStart   = 1'b1;
    wDecrypt = dec;
    wKeyCD   = key;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    @(negedge wClk);
    wStart = 1'b0;
    chk("load", 64'(load), 64'd1);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_ren", 64'(ren), 64'd0);
    for (int i = 0; i < nr; i++) begin
      @(negedge wClk);
      if (disturb) begin
        wStart   = i[0];
        wDecrypt = ~dec;
        wKeyCD   = 56'({$urandom(), $urandom()});
        wAck     = 1'b1;
      end
      chk("round_en", 64'(ren), 64'd1);
      chk("round_ld_fin", 64'({load, fin}), 64'd0);
      chk("round_idx", 64'(rnd), 64'(i));
      expk     = exp_q.pop_front();
      obs_k[i] = sk;
      chk("subkey", 64'(sk), 64'(expk));
    end
    @(negedge wClk);
    wStart   = 1'b0;
    wAck     = 1'b0;
    wDecrypt = dec;
    wKeyCD   = key;
    chk("final", 64'(fin), 64'd1);
    chk("final_busy", 64'({busy, ren, load}), 64'b100);
    chk("final_idx_hold", 64'(rnd), 64'(nr - 1));
    chk("final_key_hold", 64'(sk), 64'(expk));
    @(negedge wClk);
    chk("done", 64'(done), 64'd1);
    chk("done_busy_fin", 64'({busy, fin}), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic ack_only();
    wAck = 1'b1;
    @(negedge wClk);
    wAck = 1'b0;
    chk("ack_drop", 64'(done), 64'd0);
    chk("ack_idle", 64'({busy, load}), 64'd0);
  endtask

  initial begin
    wReset   = 1'b1;
    wStart   = 1'b0;
    wDecrypt = 1'b0;
    wAck     = 1'b0;
    wKeyCD   = '0;
    sel4     = 1'b0;
    repeat (2) @(negedge wClk);
    chk("rst_strobes", 64'({busy, load, ren, fin, done}), 64'd0);
    chk("rst_round", 64'(rnd), 64'd0);
    chk("rst_key", 64'(sk), 64'd0);
    wReset = 1'b0;
    @(negedge wClk);

    run_op(1'b0, K, 16, 1'b0);
    chk("enc_r0", 64'(obs_k[0]), 64'({28'h0000002, 28'h0000001}));
    chk("enc_r1", 64'(obs_k[1]), 64'({28'h0000004, 28'h0000002}));
    chk("enc_r2", 64'(obs_k[2]), 64'({28'h0000010, 28'h0000008}));
    chk("enc_r15", 64'(obs_k[15]), 64'({28'h0000001, 28'h8000000}));

    for (int i = 0; i < 10; i++) begin
      @(negedge wClk);
      chk("hold_done", 64'(done), 64'd1);
      chk("hold_quiet", 64'({busy, load, ren, fin}), 64'd0);
    end
    wAck   = 1'b1;
    wStart = 1'b1;
    @(negedge wClk);
    wAck = 1'b0;
    chk("ack_start_done", 64'(done), 64'd0);
    chk("ack_start_ignored", 64'({busy, load}), 64'd0);

    run_op(1'b1, K, 16, 1'b0);
    chk("dec_r0", 64'(obs_k[0]), 64'({28'h0000001, 28'h8000000}));
    chk("dec_r1", 64'(obs_k[1]), 64'({28'h8000000, 28'h4000000}));
    chk("dec_r2", 64'(obs_k[2]), 64'({28'h2000000, 28'h1000000}));
    chk("dec_r15", 64'(obs_k[15]), 64'({28'h0000002, 28'h0000001}));
    ack_only();

    run_op(1'b0, 56'h0123456_89ABCDE, 16, 1'b1);
    ack_only();
    run_op(1'b1, 56'hFEDCBA9_7654321, 16, 1'b1);
    ack_only();

    wStart   = 1'b1;
    wDecrypt = 1'b0;
    wKeyCD   = K;
    @(negedge wClk);
    wStart = 1'b0;
    repeat (8) @(negedge wClk);
    chk("mid_round_en", 64'(ren), 64'd1);
    chk("mid_round_idx", 64'(rnd), 64'd7);
    wReset = 1'b1;
    @(negedge wClk);
    wReset = 1'b0;
    chk("abort_strobes", 64'({busy, load, ren, fin, done}), 64'd0);
    chk("abort_round", 64'(rnd), 64'd0);
    chk("abort_key", 64'(sk), 64'd0);
    run_op(1'b0, K, 16, 1'b0);
    ack_only();

    wReset = 1'b1;
    @(negedge wClk);
    wReset = 1'b0;
    sel4   = 1'b1;
    chk("r4_rst", 64'({busy, done, rnd}), 64'd0);
    run_op(1'b0, K, 4, 1'b0);
    chk("r4_enc_r3", 64'(obs_k[3]), 64'({28'h0000040, 28'h0000020}));
    ack_only();
    run_op(1'b1, K, 4, 1'b0);
    chk("r4_dec_r0", 64'(obs_k[0]), 64'({28'h0000040, 28'h0000020}));
    chk("r4_dec_r3", 64'(obs_k[3]), 64'({28'h0000002, 28'h0000001}));
    ack_only();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
